// File: rtl/conv_accum_quant.sv
// conv_accum_quant
//   Accumulates NUM_PASSES signed partial sums from an adder tree, adds a
//   bias, then requantizes through a three-register pipeline:
//     A: group sum + bias, with scale/shift/relu captured alongside
//     B: signed product sum * scale
//     C: rounding right shift, optional ReLU, saturation to OUT_WIDTH
//   If the last beat of a group is driven in cycle T, o_valid pulses in
//   cycle T+3.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   i_data     signed partial sum (IN_WIDTH)
//   i_valid    i_data qualifier, at most one beat per cycle
//   i_bias     signed bias (ACC_WIDTH), static within a group
//   i_scale    unsigned requant multiplier (16)
//   i_shift    requant right shift, 0..31
//   i_relu_en  clamp negative results to zero
//   i_clear    synchronous abort of the open group and all in-flight results
//   o_data     signed quantized result, held until the next o_valid
//   o_valid    one-cycle pulse per completed group
//   o_busy     high while a group is partially accumulated
module conv_accum_quant #(
    parameter int IN_WIDTH   = 21,
    parameter int NUM_PASSES = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_valid,
    input  logic [ACC_WIDTH-1:0] i_bias,
    input  logic [15:0]          i_scale,
    input  logic [4:0]           i_shift,
    input  logic                 i_relu_en,
    input  logic                 i_clear,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy
);

    localparam int CNT_W  = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int PROD_W = ACC_WIDTH + 17;

    localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(NUM_PASSES - 1);
    localparam logic signed [PROD_W-1:0] OUT_MAX  = PROD_W'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [PROD_W-1:0] OUT_MIN  = PROD_W'(-(2 ** (OUT_WIDTH - 1)));

    // Accumulation state
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        busy_q;

    // Pipeline valids
    logic a_valid_q, b_valid_q, o_valid_q;

    // Pipeline data
    logic signed [ACC_WIDTH-1:0] a_sum_q;
    logic [15:0]                 a_scale_q;
    logic [4:0]                  a_shift_q;
    logic                        a_relu_q;
    logic signed [PROD_W-1:0]    b_prod_q;
    logic [4:0]                  b_shift_q;
    logic                        b_relu_q;
    logic [OUT_WIDTH-1:0]        o_data_q;

    // Combinational intermediates
    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] sum_a_d;
    logic                        last_beat;
    logic signed [PROD_W-1:0]    prod_d;
    logic signed [PROD_W-1:0]    rnd;
    logic signed [PROD_W-1:0]    shifted;
    logic [OUT_WIDTH-1:0]        quant_d;

    assign data_ext = ACC_WIDTH'($signed(i_data));

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block so no path leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        // The first beat of a group starts from zero, which also makes the
        // single-pass case (cnt always 0) fall out naturally.
        acc_sum   = ((cnt_q == '0) ? '0 : acc_q) + data_ext;
        sum_a_d   = acc_sum + $signed(i_bias);
        last_beat = i_valid && (cnt_q == LAST_CNT);

        if (i_clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (i_valid) begin
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            acc_d = acc_sum;
        end
    end

    // Scale is zero-extended so the multiply stays signed.
    assign prod_d = PROD_W'(a_sum_q) * PROD_W'($signed({1'b0, a_scale_q}));

    always_comb begin
        rnd     = '0;
        quant_d = '0;
        if (b_shift_q != 5'd0) begin
            rnd = PROD_W'(1) <<< (b_shift_q - 5'd1);
        end
        // Round half up, then arithmetic shift.
        shifted = (b_prod_q + rnd) >>> b_shift_q;
        if (b_relu_q && (shifted < 0)) begin
            shifted = '0;
        end
        if (shifted > OUT_MAX) begin
            quant_d = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            quant_d = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            quant_d = shifted[OUT_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            busy_q    <= (cnt_d != '0);
            a_valid_q <= last_beat && !i_clear;
            b_valid_q <= a_valid_q && !i_clear;
            o_valid_q <= b_valid_q && !i_clear;
            if (b_valid_q && !i_clear) begin
                o_data_q <= quant_d;
            end
        end
    end

    // NOTE: stage A/B data registers carry no reset; their contents are only
    // consumed when the matching valid is set, and that valid is reset.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            a_sum_q   <= sum_a_d;
            a_scale_q <= i_scale;
            a_shift_q <= i_shift;
            a_relu_q  <= i_relu_en;
        end
        if (a_valid_q) begin
            b_prod_q  <= prod_d;
            b_shift_q <= a_shift_q;
            b_relu_q  <= a_relu_q;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_conv_accum_quant.sv
// Self-checking bench for conv_accum_quant (default parameters).
// The driver pushes the expected result of each completed group, with the
// clock edge on which o_valid must appear, into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever o_valid is high, and also
// checks o_busy and o_data hold every cycle.
module tb_conv_accum_quant;

    localparam int IN_WIDTH   = 21;
    localparam int NUM_PASSES = 4;
    localparam int ACC_WIDTH  = 32;
    localparam int OUT_WIDTH  = 8;

    typedef struct {
        longint data;
        int     due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [IN_WIDTH-1:0]  i_data;
    logic                 i_valid;
    logic [ACC_WIDTH-1:0] i_bias;
    logic [15:0]          i_scale;
    logic [4:0]           i_shift;
    logic                 i_relu_en;
    logic                 i_clear;
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 o_busy;

    int     checks  = 0;
    int     errors  = 0;
    int     edges   = 0;
    bit     started = 1'b0;
    longint last_out = 0;
    exp_t   sb[$];
    int     grp[$];
    exp_t   mon_e;

    conv_accum_quant #(
        .IN_WIDTH  (IN_WIDTH),
        .NUM_PASSES(NUM_PASSES),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_bias   (i_bias),
        .i_scale  (i_scale),
        .i_shift  (i_shift),
        .i_relu_en(i_relu_en),
        .i_clear  (i_clear),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole group.
    function automatic longint model(input int s, input int bias, input int scale,
                                     input int shift, input bit relu);
        int     t;
        longint p, r;
        longint hi, lo;
        hi = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_WIDTH - 1));
        t  = s + bias;                      // 32-bit wrap like the accumulator
        p  = longint'(t) * longint'(scale);
        if (shift > 0) r = (p + (longint'(1) <<< (shift - 1))) >>> shift;
        else           r = p;
        if (relu && r < 0) r = 0;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic junk_inputs();
        i_data    = IN_WIDTH'($urandom);
        i_bias    = $urandom;
        i_scale   = 16'($urandom);
        i_shift   = 5'($urandom);
        i_relu_en = 1'($urandom);
    endtask

    // Drop expectations whose output would appear on or after the current edge.
    task automatic flush();
        while (sb.size() != 0 && sb[$].due >= edges) void'(sb.pop_back());
    endtask

    task automatic beat(input int d, input int bias, input int scale,
                        input int shift, input bit relu);
        int s;
        i_valid   = 1'b1;
        i_data    = IN_WIDTH'(d);
        i_bias    = ACC_WIDTH'(bias);
        i_scale   = 16'(scale);
        i_shift   = 5'(shift);
        i_relu_en = relu;
        i_clear   = 1'b0;
        @(posedge clk); #1;
        grp.push_back(d);
        if (grp.size() == NUM_PASSES) begin
            s = 0;
            foreach (grp[k]) s += grp[k];
            sb.push_back('{model(s, bias, scale, shift, relu), edges + 2});
            grp.delete();
        end
        i_valid = 1'b0;
        junk_inputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b0;
            junk_inputs();
            @(posedge clk); #1;
        end
    endtask

    task automatic send_group(input int d0, input int d1, input int d2, input int d3,
                              input int bias, input int scale, input int shift,
                              input bit relu, input int gap_max);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < NUM_PASSES; k++) begin
            beat(d[k], bias, scale, shift, relu);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic clear_pulse(input bit with_valid);
        i_clear = 1'b1;
        i_valid = with_valid;
        @(posedge clk); #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        grp.delete();
        flush();
    endtask

    task automatic reset_pulse(input bit with_beat, input int d);
        if (with_beat) begin
            i_valid = 1'b1;
            i_data  = IN_WIDTH'(d);
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", $signed(o_data), 0);
        check("rst_o_busy", o_busy, 0);
        grp.delete();
        flush();
        last_out = 0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        i_valid = 1'b0;
    endtask

    task automatic random_group(input int gap_max);
        int d[4];
        int bias, scale, shift;
        bit relu;
        bit wide;
        wide = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 4; k++) begin
            if (wide) d[k] = int'($urandom_range(0, 2097151)) - 1048576;
            else      d[k] = int'($urandom_range(0, 200)) - 100;
        end
        bias  = int'($urandom_range(0, 1000)) - 500;
        scale = wide ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
        shift = wide ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
        relu  = 1'($urandom);
        send_group(d[0], d[1], d[2], d[3], bias, scale, shift, relu, gap_max);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (started) begin
            check("o_busy", o_busy, grp.size() != 0);
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", o_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("o_data", $signed(o_data), mon_e.data);
                    check("latency_edge", edges, mon_e.due);
                    last_out = mon_e.data;
                end
            end else begin
                check("o_data_hold", $signed(o_data), last_out);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        junk_inputs();
        #1;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_data", $signed(o_data), 0);
        check("reset_o_busy", o_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        started = 1'b1;
        idle(2);

        // Basic accumulation
        send_group(10, 20, 30, 40, 0, 1, 0, 1'b0, 0);
        idle(5);

        // Rounding
        send_group(1, 1, 1, 0, 0, 1, 1, 1'b0, 0);     // 3  -> 2
        send_group(-1, -1, -1, 0, 0, 1, 1, 1'b0, 0);  // -3 -> -1
        send_group(25, 25, 25, 25, 28, 3, 2, 1'b0, 0); // -> 96
        idle(4);

        // Saturation and ReLU
        send_group(250, 250, 250, 250, 0, 1, 0, 1'b0, 0);
        send_group(-250, -250, -250, -250, 0, 1, 0, 1'b0, 0);
        send_group(-250, -250, -250, -250, 0, 1, 0, 1'b1, 0);
        send_group(-5, 0, 0, 0, 0, 1, 0, 1'b1, 0);
        idle(4);

        // Throughput: back-to-back, then with random gaps
        for (int g = 0; g < 3; g++) random_group(0);
        idle(4);
        for (int g = 0; g < 3; g++) random_group(3);
        idle(4);

        // Abort mid-group, then just after a last beat
        beat(7, 0, 1, 0, 1'b0);
        beat(8, 0, 1, 0, 1'b0);
        clear_pulse(1'b0);
        send_group(1, 2, 3, 4, 5, 2, 1, 1'b0, 0);
        clear_pulse(1'b0);
        send_group(11, 12, 13, 14, -3, 5, 2, 1'b0, 0);
        idle(2);
        beat(9, 0, 1, 0, 1'b0);
        clear_pulse(1'b1);                             // simultaneous beat dropped
        send_group(-20, 5, 6, 7, 100, 1, 0, 1'b0, 1);
        idle(4);

        // Reset during beat 3, then during pipeline stage B
        beat(30, 0, 1, 0, 1'b0);
        beat(31, 0, 1, 0, 1'b0);
        reset_pulse(1'b1, 32);
        send_group(2, 4, 6, 8, 1, 4, 1, 1'b0, 0);
        idle(4);
        send_group(50, 50, 50, 50, 0, 1, 0, 1'b0, 0);
        idle(1);
        reset_pulse(1'b0, 0);
        send_group(-9, 3, 3, 3, 0, 7, 0, 1'b0, 0);
        idle(4);

        // Random soak
        for (int g = 0; g < 40; g++) random_group($urandom_range(0, 2));

        // Drain
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        idle(3);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
